// File: rtl/tug_press_gen.sv
// Tug-of-war player input front end: synchronize, debounce and pulse-shape two buttons into L/R strobes.
// Optional computer opponent on the right player when TUG_CPU_PLAYER_EN is defined.
module tug_press_gen #(
  parameter int DEBOUNCE = 4,
  parameter int LFSR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_l_n,
  input  logic              key_r_n,
  input  logic              game_over,
  input  logic              cpu_en,
  input  logic [LFSR_W-1:0] cpu_level,
  output logic              L,
  output logic              R
);

  // state        | meaning
  // ST_IDLE      | released and armed, next press gives a strobe
  // ST_HELD      | press already consumed, waiting for release
  // ST_RELEASING | release seen, counting stable released samples
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HELD      = 2'd1;
  localparam logic [1:0] ST_RELEASING = 2'd2;

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // index 0 = left player, index 1 = right player
  logic [1:0]          raw_p;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0][1:0]     state;
  logic [1:0][CW-1:0]  cnt;
  logic [1:0]          req;
  logic                r_src;

  assign raw_p = {~key_r_n, ~key_l_n};

  // Synchronizers reset to "pressed" so a key held through reset is treated as already consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= raw_p;
      sync2 <= sync1;
    end
  end

  always_comb begin
    req = '0;
    for (int i = 0; i < 2; i++) begin
      req[i] = (state[i] == ST_IDLE) && sync2[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        state[i] <= ST_HELD;
        cnt[i]   <= '0;
      end else begin
        case (state[i])
          ST_IDLE: begin
            if (sync2[i]) state[i] <= ST_HELD;
          end
          ST_HELD: begin
            if (!sync2[i]) begin
              state[i] <= ST_RELEASING;
              cnt[i]   <= '0;
            end
          end
          ST_RELEASING: begin
            if (sync2[i]) begin
              state[i] <= ST_HELD;
            end else if (cnt[i] == CNT_LAST) begin
              state[i] <= ST_IDLE;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: state[i] <= ST_HELD;
        endcase
      end
    end
  end

`ifdef TUG_CPU_PLAYER_EN
  logic [LFSR_W-1:0] lfsr;

  // Free-running, including during game_over, so the opponent pattern keeps evolving.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= '1;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[9] ^ lfsr[6]};
    end
  end

  assign r_src = cpu_en ? (lfsr < cpu_level) : req[1];
`else
  logic unused_cpu;
  assign unused_cpu = ^{cpu_en, cpu_level};
  assign r_src      = req[1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      L <= 1'b0;
      R <= 1'b0;
    end else begin
      L <= req[0] & ~game_over;
      R <= r_src & ~game_over;
    end
  end

endmodule
